// File: rtl/iter_shift_unit.sv
`default_nettype none
// ============================================================================
// Module   : iter_shift_unit
// Brief    : Multi-cycle shifter. It applies one single-position shift per clock.
// Revision : 1.0  initial release
// ============================================================================
module iter_shift_unit #(
  parameter int N  = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_start,
  input  logic [N-1:0]  i_in,
  input  logic [1:0]    i_shift,
  input  logic [AW-1:0] i_amount,
  output logic [N-1:0]  o_out,
  output logic          o_busy,
  output logic          o_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [N-1:0]  r_acc;
  logic [AW-1:0] r_cnt;
  logic [1:0]    r_op;
  logic [N-1:0]  r_out;
  logic [N-1:0]  w_step;
  logic          w_zero_len;

  // A pass op or a zero amount skips SHIFT and goes straight to DONE.
  assign w_zero_len = (i_amount == '0) || (i_shift == 2'b00);

  always_comb begin
    w_step = r_acc;
    case (r_op)
      2'b01:   w_step = {r_acc[N-2:0], 1'b0};
      2'b10:   w_step = {1'b0, r_acc[N-1:1]};
      2'b11:   w_step = {r_acc[N-1], r_acc[N-1:1]};
      default: w_step = r_acc;
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_next_state = w_zero_len ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_cnt == AW'(1)) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_op    <= 2'b00;
      r_out   <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_acc <= i_in;
            r_op  <= i_shift;
            r_cnt <= i_amount;
            if (w_zero_len) begin
              r_out <= i_in;
            end
          end
        end
        S_SHIFT: begin
          r_acc <= w_step;
          r_cnt <= r_cnt - AW'(1);
          if (r_cnt == AW'(1)) begin
            r_out <= w_step;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_out  = r_out;
  assign o_busy = (r_state != S_IDLE);
  assign o_done = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_iter_shift_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_iter_shift_unit
// Brief    : Self-checking bench for iter_shift_unit. It compares the DUT against an arithmetic shift model.
// Revision : 1.0  initial release
// ============================================================================
module tb_iter_shift_unit;
  localparam int N  = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          i_start;
  logic [N-1:0]  i_in;
  logic [1:0]    i_shift;
  logic [AW-1:0] i_amount;
  logic [N-1:0]  o_out;
  logic          o_busy;
  logic          o_done;

  int errors = 0;
  int checks = 0;
  logic [N-1:0] last_out;

  iter_shift_unit #(.N(N), .AW(AW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_start  (i_start),
    .i_in     (i_in),
    .i_shift  (i_shift),
    .i_amount (i_amount),
    .o_out    (o_out),
    .o_busy   (o_busy),
    .o_done   (o_done)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] ref_result(logic [N-1:0] v, logic [1:0] op, int amt);
    logic signed [N-1:0] sv;
    sv = v;
    case (op)
      2'b01:   return v << amt;
      2'b10:   return v >> amt;
      2'b11:   return sv >>> amt;
      default: return v;
    endcase
  endfunction

  function automatic int ref_lat(logic [1:0] op, int amt);
    return (op == 2'b00 || amt == 0) ? 0 : amt;
  endfunction

  // Stimulus only: present a request for one edge, then scramble the inputs.
  task automatic start_op(logic [N-1:0] v, logic [1:0] op, logic [AW-1:0] amt);
    @(negedge clk);
    i_start  = 1'b1;
    i_in     = v;
    i_shift  = op;
    i_amount = amt;
    @(posedge clk);
    #1;
    i_start  = 1'b0;
    i_in     = N'($urandom);
    i_shift  = 2'($urandom);
    i_amount = AW'($urandom);
  endtask

  // Observation only: follow the busy window and record what was seen.
  task automatic observe(output int busy_cyc, output int done_idx, output int pulses,
                         output logic [N-1:0] out_first, output logic [N-1:0] out_done);
    busy_cyc  = 0;
    done_idx  = -1;
    pulses    = 0;
    out_first = o_out;
    out_done  = 'x;
    while (o_busy && busy_cyc < 64) begin
      if (o_done) begin
        pulses++;
        if (done_idx < 0) done_idx = busy_cyc;
        out_done = o_out;
      end
      busy_cyc++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; i_start = 1'b0; i_in = '0; i_shift = 2'b00; i_amount = '0;
    #12;
    checks++;
    if ({o_out, o_busy, o_done} !== {{N{1'b0}}, 2'b00}) begin
      errors++; $display("FAIL reset_in: out=%h busy=%b done=%b exp 0/0/0", o_out, o_busy, o_done);
    end
    @(negedge clk); reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({o_out, o_busy, o_done} !== {{N{1'b0}}, 2'b00}) begin
      errors++; $display("FAIL reset_idle: out=%h busy=%b done=%b exp 0/0/0", o_out, o_busy, o_done);
    end
    last_out = '0;
  endtask

  task automatic test_left();
    int b, d, p; logic [N-1:0] f, o;
    start_op(16'h000F, 2'b01, 4'd4);
    observe(b, d, p, f, o);
    checks++; if (b !== 5) begin errors++; $display("FAIL left_busy: got %0d exp 5", b); end
    checks++; if (d !== 4 || p !== 1) begin errors++; $display("FAIL left_done: idx %0d pulses %0d exp 4/1", d, p); end
    checks++; if (f !== last_out) begin errors++; $display("FAIL left_hold_before: got %h exp %h", f, last_out); end
    checks++; if (o !== 16'h00F0) begin errors++; $display("FAIL left_out: got %h exp 00f0", o); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (o_out !== 16'h00F0 || o_busy !== 1'b0) begin
      errors++; $display("FAIL left_hold_after: out=%h busy=%b exp 00f0/0", o_out, o_busy);
    end
    last_out = 16'h00F0;
  endtask

  task automatic test_arith();
    int b, d, p; logic [N-1:0] f, o;
    start_op(16'h8000, 2'b11, 4'd3);
    observe(b, d, p, f, o);
    checks++; if (o !== 16'hF000 || b !== 4) begin errors++; $display("FAIL arith_neg: out %h busy %0d exp f000/4", o, b); end
    start_op(16'h4000, 2'b11, 4'd3);
    observe(b, d, p, f, o);
    checks++; if (o !== 16'h0800 || d !== 3) begin errors++; $display("FAIL arith_pos: out %h idx %0d exp 0800/3", o, d); end
    last_out = 16'h0800;
  endtask

  task automatic test_logical_max();
    int b, d, p; logic [N-1:0] f, o;
    start_op(16'h8000, 2'b10, 4'd15);
    observe(b, d, p, f, o);
    checks++; if (b !== 16 || d !== 15) begin errors++; $display("FAIL lsr_max_lat: busy %0d idx %0d exp 16/15", b, d); end
    checks++; if (o !== 16'h0001) begin errors++; $display("FAIL lsr_max_out: got %h exp 0001", o); end
    last_out = 16'h0001;
  endtask

  task automatic test_zero_len();
    int b, d, p; logic [N-1:0] f, o;
    start_op(16'hA5A5, 2'b00, 4'd7);
    observe(b, d, p, f, o);
    checks++; if (b !== 1 || d !== 0 || o !== 16'hA5A5) begin
      errors++; $display("FAIL zero_pass: busy %0d idx %0d out %h exp 1/0/a5a5", b, d, o);
    end
    start_op(16'h0000, 2'b01, 4'd3);
    observe(b, d, p, f, o);
    start_op(16'hA5A5, 2'b01, 4'd0);
    observe(b, d, p, f, o);
    checks++; if (b !== 1 || d !== 0 || o !== 16'hA5A5) begin
      errors++; $display("FAIL zero_amount: busy %0d idx %0d out %h exp 1/0/a5a5", b, d, o);
    end
    last_out = 16'hA5A5;
  endtask

  task automatic test_ignored_start();
    int c;
    start_op(16'h0003, 2'b01, 4'd6);
    c = 0;
    while (!o_done && c < 50) begin
      if (c == 2) begin
        i_start = 1'b1; i_in = 16'hFFFF; i_shift = 2'b00; i_amount = '0;
      end else begin
        i_start = 1'b0;
      end
      @(posedge clk);
      #1;
      c++;
    end
    checks++; if (c !== 6 || o_out !== 16'h00C0 || o_busy !== 1'b1) begin
      errors++; $display("FAIL ign_mid: cycle %0d out %h busy %b exp 6/00c0/1", c, o_out, o_busy);
    end
    i_start = 1'b1; i_in = 16'hFFFF; i_shift = 2'b00; i_amount = '0;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    checks++; if (o_busy !== 1'b0 || o_done !== 1'b0 || o_out !== 16'h00C0) begin
      errors++; $display("FAIL ign_done: busy %b done %b out %h exp 0/0/00c0", o_busy, o_done, o_out);
    end
    @(posedge clk);
    #1;
    checks++; if (o_busy !== 1'b0 || o_out !== 16'h00C0) begin
      errors++; $display("FAIL ign_after: busy %b out %h exp 0/00c0", o_busy, o_out);
    end
    last_out = 16'h00C0;
  endtask

  task automatic test_reset_abort();
    int b, d, p, pulses; logic [N-1:0] f, o;
    start_op(16'h1234, 2'b01, 4'd8);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    checks++; if (o_out !== '0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
      errors++; $display("FAIL abort_async: out %h busy %b done %b exp 0/0/0", o_out, o_busy, o_done);
    end
    @(negedge clk); reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (o_done || o_busy) pulses++;
    end
    checks++; if (pulses !== 0 || o_out !== '0) begin
      errors++; $display("FAIL abort_quiet: activity %0d out %h exp 0/0000", pulses, o_out);
    end
    start_op(16'h8000, 2'b11, 4'd3);
    observe(b, d, p, f, o);
    checks++; if (o !== 16'hF000 || b !== 4 || p !== 1) begin
      errors++; $display("FAIL abort_recover: out %h busy %0d pulses %0d exp f000/4/1", o, b, p);
    end
    last_out = 16'hF000;
  endtask

  task automatic test_random();
    int b, d, p, lat; logic [N-1:0] f, o, v, exp_out; logic [1:0] op; logic [AW-1:0] amt;
    for (int t = 0; t < 40; t++) begin
      v   = N'($urandom);
      op  = 2'($urandom);
      amt = AW'($urandom);
      exp_out = ref_result(v, op, int'(amt));
      lat     = ref_lat(op, int'(amt));
      start_op(v, op, amt);
      observe(b, d, p, f, o);
      checks++; if (o !== exp_out) begin
        errors++; $display("FAIL rand_out[%0d]: in %h op %b amt %0d got %h exp %h", t, v, op, amt, o, exp_out);
      end
      checks++; if (b !== lat + 1 || d !== lat || p !== 1) begin
        errors++; $display("FAIL rand_lat[%0d]: busy %0d idx %0d pulses %0d exp %0d/%0d/1", t, b, d, p, lat + 1, lat);
      end
      checks++; if (f !== ((lat == 0) ? exp_out : last_out)) begin
        errors++; $display("FAIL rand_hold[%0d]: got %h exp %h", t, f, (lat == 0) ? exp_out : last_out);
      end
      last_out = exp_out;
      if ($urandom_range(0, 2) == 0) @(posedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_left();
    test_arith();
    test_logical_max();
    test_zero_len();
    test_ignored_start();
    test_reset_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
